// File: rtl/adder_sum_tx_if.sv
// Valid/ready handshake carrying 5-bit sum words into the serial transmitter.
interface adder_sum_tx_if;
  logic [4:0] sum;
  logic       sum_valid;
  logic       sum_ready;

  modport master (
    output sum,
    output sum_valid,
    input  sum_ready
  );

  modport slave (
    input  sum,
    input  sum_valid,
    output sum_ready
  );
endinterface

// File: rtl/adder_sum_tx.sv
// Serial transmitter for adder sums: 2-deep FIFO feeding a framed UART-style
// line (start, 5 data bits LSB-first, even parity, stop), CLKS_PER_BIT cycles/bit.
module adder_sum_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  adder_sum_tx_if.slave sum_if,
  output logic          tx_data,
  output logic          tx_busy,
  output logic          tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_n;
  logic [7:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [4:0] shift, shift_n;
  logic       parity, parity_n;

  logic [4:0] mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic [4:0] head;
  logic       push, pop;
  logic       bit_end;
  logic       line_n, done_n;

  assign sum_if.sum_ready = (count != 2'd2);
  assign push             = sum_if.sum_valid & sum_if.sum_ready & ena;
  assign head             = mem[rd_ptr];
  assign bit_end          = (baud == BAUD_LAST);

  // Two-entry in-order FIFO; push and pop in the same cycle keep the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (ena) begin
      if (push) begin
        mem[wr_ptr] <= sum_if.sum;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FSM, baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      parity  <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      parity  <= parity_n;
    end
  end

  // Next-state logic; everything holds while ena is low.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_idx;
    shift_n  = shift;
    parity_n = parity;
    pop      = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            pop      = 1'b1;
            shift_n  = head;
            parity_n = ^head;
            baud_n   = '0;
            bit_n    = '0;
            state_n  = START;
          end
        end
        default: begin
          if (!bit_end) begin
            baud_n = baud + 8'd1;
          end else begin
            baud_n = '0;
            case (state)
              START: begin
                bit_n   = '0;
                state_n = DATA;
              end
              DATA: begin
                shift_n = shift >> 1;
                if (bit_idx == 3'd4) state_n = PARITY;
                else                 bit_n   = bit_idx + 3'd1;
              end
              PARITY: state_n = STOP;
              STOP: begin
                // Back-to-back frames: reload straight into START, no idle gap.
                if (count != 2'd0) begin
                  pop      = 1'b1;
                  shift_n  = head;
                  parity_n = ^head;
                  bit_n    = '0;
                  state_n  = START;
                end else begin
                  state_n  = IDLE;
                end
              end
              default: state_n = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Line value and done flag for the coming cycle, derived from next state.
  always_comb begin
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      PARITY:  line_n = parity_n;
      default: line_n = 1'b1;
    endcase
    done_n = (state_n == STOP) && (baud_n == BAUD_LAST);
  end

  // Registered outputs so the serial line is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (ena) begin
      tx_data <= line_n;
      tx_busy <= (state_n != IDLE);
      tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_adder_sum_tx.sv
// Directed bench for adder_sum_tx: CLKS_PER_BIT=4 instance for framing/timing
// cases, CLKS_PER_BIT=1 instance for the full 32-value sweep via a receiver.
module tb_adder_sum_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ena = 1'b1;
  logic tx4, busy4, done4;
  logic tx1, busy1, done1;

  adder_sum_tx_if if4();
  adder_sum_tx_if if1();

  adder_sum_tx #(.CLKS_PER_BIT(4)) u4 (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .sum_if  (if4),
    .tx_data (tx4),
    .tx_busy (busy4),
    .tx_done (done4)
  );

  adder_sum_tx #(.CLKS_PER_BIT(1)) u1 (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .sum_if  (if1),
    .tx_data (tx1),
    .tx_busy (busy1),
    .tx_done (done1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Receiver for the CLKS_PER_BIT=1 line, one sample per cycle.
  int         rx_idx = 0;
  logic [4:0] rx_bits;
  logic       rx_par;
  int         rx_count = 0;
  int         first_start = -1;
  int         last_stop = 0;
  logic [4:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      rx_idx = 0;
    end else if (rx_idx == 0) begin
      if (tx1 == 1'b0) begin
        rx_idx = 1;
        if (first_start < 0) first_start = cyc;
      end
    end else if (rx_idx <= 5) begin
      rx_bits[rx_idx-1] = tx1;
      rx_idx++;
    end else if (rx_idx == 6) begin
      rx_par = tx1;
      rx_idx = 7;
    end else begin
      check("rx_stop", tx1, 1);
      check("rx_even_parity", ^{rx_bits, rx_par}, 0);
      check("rx_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("rx_data", rx_bits, exp_q.pop_front());
      rx_count++;
      last_stop = cyc;
      rx_idx = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] sum;
    logic [7:0] frame;   // {stop, parity, d4..d0, start}; bit 0 goes out first
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] bb[3];
    logic [7:0] fr;
    int ndone, ones, c, g;

    vecs[0] = '{5'b10110, 8'b11101100};
    vecs[1] = '{5'b00000, 8'b10000000};
    vecs[2] = '{5'b11111, 8'b11111110};
    vecs[3] = '{5'b00001, 8'b11000010};
    vecs[4] = '{5'b00100, 8'b11001000};
    vecs[5] = '{5'b01011, 8'b11010110};
    vecs[6] = '{5'b10001, 8'b10100010};
    vecs[7] = '{5'b11000, 8'b10110000};
    bb[0] = 8'b10000000;
    bb[1] = 8'b11111110;
    bb[2] = 8'b11000010;

    if4.sum = '0; if4.sum_valid = 1'b0;
    if1.sum = '0; if1.sum_valid = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx_data", tx4, 1);
    check("rst_tx_busy", busy4, 0);
    check("rst_sum_ready", if4.sum_ready, 1);
    check("rst_tx_done", done4, 0);
    check("rst1_tx_data", tx1, 1);
    check("rst1_sum_ready", if1.sum_ready, 1);

    // Single frames from the vector table, cycle-exact
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ready_before", if4.sum_ready, 1);
      if4.sum = vecs[i].sum;
      if4.sum_valid = 1'b1;
      @(negedge clk);
      if4.sum_valid = 1'b0;
      check("idle_after_accept", tx4, 1);
      check("busy_after_accept", busy4, 0);
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        check("frame_line", tx4, vecs[i].frame[k/4]);
        check("frame_busy", busy4, 1);
        check("frame_done", done4, k == 31);
      end
      @(negedge clk);
      check("end_busy", busy4, 0);
      check("end_line", tx4, 1);
      check("end_done", done4, 0);
    end

    // Back-to-back: three words with valid held high
    @(negedge clk);
    if4.sum = 5'b00000;
    if4.sum_valid = 1'b1;
    ndone = 0;
    for (int k = 0; k <= 97; k++) begin
      @(negedge clk);
      check("bb_ready", if4.sum_ready, (k < 2 || k >= 33));
      if (k >= 1 && k <= 96) begin
        c = k - 1;
        check("bb_line", tx4, bb[c/32][(c%32)/4]);
        check("bb_busy", busy4, 1);
        check("bb_done", done4, (c % 32) == 31);
      end
      if (k == 97) begin
        check("bb_end_busy", busy4, 0);
        check("bb_end_line", tx4, 1);
      end
      if (done4) ndone++;
      if (k == 0) if4.sum = 5'b11111;
      if (k == 1) if4.sum = 5'b00001;
      if (k == 2) if4.sum_valid = 1'b0;
    end
    check("bb_done_pulses", ndone, 3);

    // ena low for 5 cycles inside data bit 2 of 5'b00100
    fr = 8'b11001000;
    ones = 0;
    @(negedge clk);
    if4.sum = 5'b00100;
    if4.sum_valid = 1'b1;
    for (int k = 0; k <= 38; k++) begin
      @(negedge clk);
      if (k == 0) if4.sum_valid = 1'b0;
      if (k <= 14)      c = k - 1;
      else if (k <= 19) c = 13;
      else              c = k - 6;
      if (k >= 1 && c <= 31) begin
        check("ena_line", tx4, fr[c/4]);
        check("ena_busy", busy4, 1);
        check("ena_done", done4, c == 31);
        if (tx4 === 1'b1) ones++;
      end
      if (k == 38) begin
        check("ena_end_busy", busy4, 0);
        check("ena_end_line", tx4, 1);
      end
      if (k == 14) ena = 1'b0;
      if (k == 19) ena = 1'b1;
    end
    check("ena_high_samples", ones, 17);

    // Reset during PARITY with a second word queued
    @(negedge clk);
    if4.sum = 5'b01011;
    if4.sum_valid = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      if (k == 0) if4.sum = 5'b10001;
      if (k == 1) if4.sum_valid = 1'b0;
    end
    check("pre_reset_parity", tx4, 1'b1);
    check("pre_reset_busy", busy4, 1);
    reset = 1'b0;
    #1;
    check("midrst_line", tx4, 1);
    check("midrst_busy", busy4, 0);
    check("midrst_ready", if4.sum_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("post_rst_line", tx4, 1);
      check("post_rst_busy", busy4, 0);
      check("post_rst_done", done4, 0);
    end
    check("post_rst_ready", if4.sum_ready, 1);

    // Parity sweep on the CLKS_PER_BIT=1 instance
    for (int v = 0; v < 32; v++) begin
      @(negedge clk);
      if1.sum = 5'(v);
      if1.sum_valid = 1'b1;
      g = 0;
      while (!if1.sum_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("sweep_ready_timeout", g < 100, 1);
      @(posedge clk);
      exp_q.push_back(5'(v));
    end
    @(negedge clk);
    if1.sum_valid = 1'b0;
    g = 0;
    while (rx_count < 32 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("sweep_rx_count", rx_count, 32);
    check("sweep_queue_empty", exp_q.size(), 0);
    check("sweep_contiguous", last_stop - first_start, 255);
    @(negedge clk);
    check("sweep_end_busy", busy1, 0);
    check("sweep_end_line", tx1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
